// File: rtl/neopix_rx.sv
// WS2812 single-wire receiver: measures high-pulse widths on a synchronized input,
// assembles 24-bit GRB pixels and reports frame completion at the latch low period.
module neopix_rx #(
    parameter int NUM_LEDS     = 8,
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int T1_MIN_NS    = 600,
    parameter int MIN_HIGH_NS  = 150,
    parameter int MAX_HIGH_NS  = 5000,
    parameter int RESET_NS     = 40000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        din_i,
    output logic [23:0]                 pixel_o,
    output logic [$clog2(NUM_LEDS)-1:0] pixel_idx_o,
    output logic                        pixel_valid_o,
    output logic                        frame_done_o,
    output logic [$clog2(NUM_LEDS):0]   led_count_o,
    output logic [2:0]                  err_o,
    output logic                        busy_o
);
    localparam longint CLK_KHZ    = longint'(SYSTEM_CLOCK / 1000);
    localparam int T1_MIN_CYC     = int'(CLK_KHZ * T1_MIN_NS / 1000000);
    localparam int MIN_HIGH_CYC   = int'(CLK_KHZ * MIN_HIGH_NS / 1000000);
    localparam int MAX_HIGH_CYC   = int'(CLK_KHZ * MAX_HIGH_NS / 1000000);
    localparam int RESET_CYC      = int'(CLK_KHZ * RESET_NS / 1000000);

    localparam int LCW = $clog2(RESET_CYC + 1);
    localparam int HCW = $clog2(MAX_HIGH_CYC + 2);
    localparam int IW  = $clog2(NUM_LEDS);
    localparam int CW  = IW + 1;

    localparam logic [LCW-1:0] LC_SAT  = LCW'(RESET_CYC);
    localparam logic [LCW-1:0] LC_LAST = LCW'(RESET_CYC - 1);
    localparam logic [HCW-1:0] HC_T1   = HCW'(T1_MIN_CYC);
    localparam logic [HCW-1:0] HC_MIN  = HCW'(MIN_HIGH_CYC);
    localparam logic [HCW-1:0] HC_MAX  = HCW'(MAX_HIGH_CYC);
    localparam logic [CW-1:0]  PIX_MAX = CW'(NUM_LEDS);

    typedef enum logic [1:0] {S_SYNC, S_LOW, S_HIGH} state_t;

    state_t           r_state, w_next;
    logic             r_sync1, r_din_s;
    logic [LCW-1:0]   r_lc;
    logic [HCW-1:0]   r_hc;
    logic [23:0]      r_shift;
    logic [4:0]       r_bit_cnt;
    logic [CW-1:0]    r_pix_cnt;
    logic             r_glitch, r_timeout, r_ovf;
    logic             w_rise, w_bit_en, w_bit, w_glitch, w_timeout, w_frame_end;
    logic [23:0]      w_word;

    assign w_word = {r_shift[22:0], w_bit};

    // NOTE: two flops only; din_i is never used before r_din_s.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sync1 <= 1'b0;
            r_din_s <= 1'b0;
            r_state <= S_SYNC;
        end else begin
            r_sync1 <= din_i;
            r_din_s <= r_sync1;
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rise      = 1'b0;
        w_bit_en    = 1'b0;
        w_bit       = 1'b0;
        w_glitch    = 1'b0;
        w_timeout   = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (!r_din_s && r_lc == LC_LAST) begin
                    w_next      = S_LOW;
                    w_frame_end = busy_o;
                end
            end
            S_LOW: begin
                if (r_din_s) begin
                    w_next = S_HIGH;
                    w_rise = 1'b1;
                end else if (r_lc == LC_LAST && busy_o) begin
                    w_frame_end = 1'b1;
                end
            end
            S_HIGH: begin
                if (!r_din_s) begin
                    w_next = S_LOW;
                    if (r_hc < HC_MIN) begin
                        w_glitch = 1'b1;
                    end else begin
                        w_bit_en = 1'b1;
                        w_bit    = (r_hc >= HC_T1);
                    end
                end else if (r_hc == HC_MAX) begin
                    w_next    = S_SYNC;
                    w_timeout = 1'b1;
                end
            end
            default: w_next = S_SYNC;
        endcase
    end

    // The high counter includes the rising cycle so r_hc equals the pulse width at the fall.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_lc          <= '0;
            r_hc          <= '0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_pix_cnt     <= '0;
            r_glitch      <= 1'b0;
            r_timeout     <= 1'b0;
            r_ovf         <= 1'b0;
            pixel_o       <= '0;
            pixel_idx_o   <= '0;
            pixel_valid_o <= 1'b0;
            frame_done_o  <= 1'b0;
            led_count_o   <= '0;
            err_o         <= '0;
            busy_o        <= 1'b0;
        end else begin
            pixel_valid_o <= 1'b0;
            frame_done_o  <= 1'b0;

            if (r_state == S_HIGH || r_din_s)
                r_lc <= '0;
            else if (r_lc < LC_SAT)
                r_lc <= r_lc + 1'b1;

            if (w_rise)
                r_hc <= HCW'(1);
            else if (r_state == S_HIGH && r_din_s)
                r_hc <= r_hc + 1'b1;

            if (w_rise)
                busy_o <= 1'b1;
            if (w_glitch)
                r_glitch <= 1'b1;

            if (w_timeout) begin
                r_timeout <= 1'b1;
                r_bit_cnt <= '0;
            end

            if (w_bit_en) begin
                r_shift <= w_word;
                if (r_bit_cnt == 5'd23) begin
                    r_bit_cnt <= '0;
                    if (r_pix_cnt < PIX_MAX) begin
                        pixel_o       <= w_word;
                        pixel_idx_o   <= r_pix_cnt[IW-1:0];
                        pixel_valid_o <= 1'b1;
                        r_pix_cnt     <= r_pix_cnt + 1'b1;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_frame_end) begin
                frame_done_o <= 1'b1;
                led_count_o  <= r_pix_cnt;
                err_o        <= {r_ovf, r_timeout | (r_bit_cnt != 5'd0), r_glitch};
                r_pix_cnt    <= '0;
                r_bit_cnt    <= '0;
                r_glitch     <= 1'b0;
                r_timeout    <= 1'b0;
                r_ovf        <= 1'b0;
                busy_o       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neopix_rx.sv
// Directed bench for neopix_rx: drives bit-accurate WS2812 waveforms and checks
// decoded pixels, frame strobes, error flags and reset behaviour.
module tb_neopix_rx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b0;
    logic [23:0] pixel;
    logic [2:0]  pixel_idx;
    logic        pixel_valid;
    logic        frame_done;
    logic [3:0]  led_count;
    logic [2:0]  err;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;
    int fd_cnt = 0;
    int both_cnt = 0;
    int fd_before;
    logic [23:0] vq_pix[$];
    logic [2:0]  vq_idx[$];
    logic [23:0] v;

    neopix_rx dut (
        .clk_i(clk), .reset_i(reset), .din_i(din),
        .pixel_o(pixel), .pixel_idx_o(pixel_idx), .pixel_valid_o(pixel_valid),
        .frame_done_o(frame_done), .led_count_o(led_count), .err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pixel_valid) begin
            vq_pix.push_back(pixel);
            vq_idx.push_back(pixel_idx);
        end
        if (frame_done)
            fd_cnt++;
        if (pixel_valid && frame_done)
            both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input int high, input int low);
        din = 1'b1;
        repeat (high) @(negedge clk);
        din = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) begin
            if (p[i]) send_bit(40, 22);
            else      send_bit(20, 42);
        end
    endtask

    task automatic clear_q();
        vq_pix.delete();
        vq_idx.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pixel", 32'(pixel), 32'h0);
        check("rst_idx", 32'(pixel_idx), 32'h0);
        check("rst_valid", 32'(pixel_valid), 32'h0);
        check("rst_done", 32'(frame_done), 32'h0);
        check("rst_count", 32'(led_count), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;

        // Test 1: two pixels, clean frame
        idle(2000);
        fd_before = fd_cnt;
        send_pixel(24'h123456);
        check("t1_busy_mid", 32'(busy), 32'h1);
        send_pixel(24'hABCDEF);
        idle(2100);
        check("t1_nvalid", 32'(vq_pix.size()), 32'd2);
        if (vq_pix.size() == 2) begin
            check("t1_pix0", 32'(vq_pix[0]), 32'h123456);
            check("t1_idx0", 32'(vq_idx[0]), 32'd0);
            check("t1_pix1", 32'(vq_pix[1]), 32'hABCDEF);
            check("t1_idx1", 32'(vq_idx[1]), 32'd1);
        end
        check("t1_ndone", 32'(fd_cnt - fd_before), 32'd1);
        check("t1_count", 32'(led_count), 32'd2);
        check("t1_err", 32'(err), 32'b000);
        check("t1_busy_end", 32'(busy), 32'h0);
        idle(2100);
        check("t1_no_repeat", 32'(fd_cnt - fd_before), 32'd1);

        // Test 2: nine pixels overflow an 8-pixel frame
        clear_q();
        fd_before = fd_cnt;
        for (int i = 0; i < 9; i++) begin
            v = 24'h102030 + 24'(i) * 24'h010101;
            send_pixel(v);
        end
        idle(2100);
        check("t2_nvalid", 32'(vq_pix.size()), 32'd8);
        if (vq_pix.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                v = 24'h102030 + 24'(i) * 24'h010101;
                check("t2_pix", 32'(vq_pix[i]), 32'(v));
            end
            check("t2_idx7", 32'(vq_idx[7]), 32'd7);
        end
        check("t2_ndone", 32'(fd_cnt - fd_before), 32'd1);
        check("t2_count", 32'(led_count), 32'd8);
        check("t2_err", 32'(err), 32'b100);

        // Test 3: partial pixel of 12 bits
        clear_q();
        fd_before = fd_cnt;
        v = 24'h000ABC;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) send_bit(40, 22);
            else      send_bit(20, 42);
        end
        idle(2100);
        check("t3_nvalid", 32'(vq_pix.size()), 32'd0);
        check("t3_ndone", 32'(fd_cnt - fd_before), 32'd1);
        check("t3_count", 32'(led_count), 32'd0);
        check("t3_err", 32'(err), 32'b010);

        // Test 4a: width boundaries 29->0, 30->1, 250->1, 7->0 (not a glitch)
        clear_q();
        fd_before = fd_cnt;
        send_bit(29, 22);
        send_bit(30, 22);
        send_bit(250, 22);
        send_bit(7, 42);
        for (int i = 0; i < 20; i++) send_bit(20, 42);
        idle(2100);
        check("t4_nvalid", 32'(vq_pix.size()), 32'd1);
        if (vq_pix.size() == 1)
            check("t4_pix", 32'(vq_pix[0]), 32'h600000);
        check("t4_count", 32'(led_count), 32'd1);
        check("t4_err", 32'(err), 32'b000);

        // Test 4b: 6-cycle glitch
        clear_q();
        fd_before = fd_cnt;
        send_bit(6, 42);
        idle(2100);
        check("t4b_nvalid", 32'(vq_pix.size()), 32'd0);
        check("t4b_ndone", 32'(fd_cnt - fd_before), 32'd1);
        check("t4b_err", 32'(err), 32'b001);

        // Test 4c: 251-cycle timeout; a pixel straight after it is ignored
        clear_q();
        fd_before = fd_cnt;
        send_bit(251, 30);
        send_pixel(24'hFFFFFF);
        idle(2100);
        check("t4c_nvalid", 32'(vq_pix.size()), 32'd0);
        check("t4c_ndone", 32'(fd_cnt - fd_before), 32'd1);
        check("t4c_count", 32'(led_count), 32'd0);
        check("t4c_err", 32'(err), 32'b010);

        // Test 5: asynchronous reset mid-pixel
        for (int i = 0; i < 10; i++) send_bit(40, 22);
        din = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_busy_pre", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("t5_pixel", 32'(pixel), 32'h0);
        check("t5_err", 32'(err), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        din = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_q();
        fd_before = fd_cnt;
        idle(500);
        send_pixel(24'h5A5A5A);
        idle(2100);
        check("t5_ign_valid", 32'(vq_pix.size()), 32'd0);
        check("t5_ign_done", 32'(fd_cnt - fd_before), 32'd0);
        send_pixel(24'hC3C3C3);
        idle(2100);
        check("t5_nvalid", 32'(vq_pix.size()), 32'd1);
        if (vq_pix.size() == 1) begin
            check("t5_pix", 32'(vq_pix[0]), 32'hC3C3C3);
            check("t5_idx", 32'(vq_idx[0]), 32'd0);
        end
        check("t5_ndone", 32'(fd_cnt - fd_before), 32'd1);
        check("t5_count", 32'(led_count), 32'd1);
        check("t5_err2", 32'(err), 32'b000);

        check("strobe_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
